// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_pkg : shared FSM states and bit-phase constants for the I2C writer    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    BYTE    = 3'd2,
    ACKS    = 3'd3,
    STOP    = 3'd4,
    BUSFREE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  localparam logic RW_WRITE      = 1'b0;
  localparam int   BITS_PER_SLOT = 9;

endpackage
`default_nettype wire

// File: rtl/i2c_master_wr_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_tick_gen : quarter-bit prescaler, one-cycle tick every CLK_DIV clocks |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_tick_gen #(
  parameter int CLK_DIV = 63
) (
  input  logic meg25,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge meg25 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/i2c_master_wr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_master_wr : open-drain I2C/SCCB write master (addr+W, reg, data)      |
// | rev 1.0  -- define I2C_NACK_RETRY_EN to re-issue a NACKed frame           |
// +--------------------------------------------------------------------------+
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV   = 63,
  parameter logic [6:0] DEV_ADDR  = 7'h3C,
  parameter int         REG_BYTES = 2,
  parameter int         DAT_BYTES = 1,
  parameter int         MAX_RETRY = 3
) (
  input  logic                                 meg25,
  input  logic                                 rst,
  input  logic                                 sendit,
  input  logic [8*(REG_BYTES+DAT_BYTES)-1:0]   send_dat,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 ack,
  output logic                                 nack_err,
  output logic [6:0]                           send_count_out,
  inout  wire                                  scl,
  inout  wire                                  sda
);

  localparam int NBYTES = 1 + REG_BYTES + DAT_BYTES;
  localparam int FW     = 8 * NBYTES;
  localparam int BCW    = $clog2(NBYTES);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  if ((CLK_DIV < 2) || (REG_BYTES < 1) || (REG_BYTES > 4) ||
      (DAT_BYTES < 1) || (DAT_BYTES > 4) || (MAX_RETRY < 0) || (MAX_RETRY > 255)) begin : g_param_check
    $error("i2c_master_wr: illegal parameter value");
  end

  state_t         state_q;
  logic [1:0]     phase_q;
  logic           scl_oe_q;
  logic           sda_oe_q;
  logic           busy_q;
  logic           done_q;
  logic           ack_q;
  logic           nack_err_q;
  logic [6:0]     count_q;
  logic           armed_q;
  logic [FW-1:0]  frame_q;
  logic [FW-1:0]  shift_q;
  logic [2:0]     bit_q;
  logic [BCW-1:0] byte_q;
  logic           slot_nack_q;
  logic           sda_meta_q;
  logic           sda_sync_q;
  logic           tick;
`ifdef I2C_NACK_RETRY_EN
  logic [7:0]     retry_q;
`endif

  i2c_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .meg25 (meg25),
    .rst   (rst),
    .en    (busy_q),
    .tick  (tick)
  );

  // SDA is only looked at in ACK slots, long after it settled; two flops
  // keep the slave-driven level out of the FSM's metastability window.
  always_ff @(posedge meg25 or posedge rst) begin
    if (rst) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= sda;
      sda_sync_q <= sda_meta_q;
    end
  end

  always_ff @(posedge meg25 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      nack_err_q  <= 1'b0;
      count_q     <= '0;
      armed_q     <= 1'b1;
      frame_q     <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      slot_nack_q <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (!sendit) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (sendit && armed_q) begin
            frame_q     <= {DEV_ADDR, RW_WRITE, send_dat};
            shift_q     <= {DEV_ADDR, RW_WRITE, send_dat};
            ack_q       <= 1'b0;
            nack_err_q  <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b1;
            armed_q     <= 1'b0;
            bit_q       <= '0;
            byte_q      <= '0;
            slot_nack_q <= 1'b0;
            phase_q     <= PH0;
`ifdef I2C_NACK_RETRY_EN
            retry_q     <= '0;
`endif
            state_q     <= START;
          end
        end

        DONE: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          ack_q      <= ~slot_nack_q;
          nack_err_q <= slot_nack_q;
          state_q    <= IDLE;
        end

        default: begin
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            case (state_q)
              START: begin
                if (phase_q == PH0) begin
                  sda_oe_q <= 1'b1;
                end else begin
                  scl_oe_q <= 1'b1;
                  phase_q  <= PH0;
                  state_q  <= BYTE;
                end
              end

              BYTE: begin
                case (phase_q)
                  PH0: sda_oe_q <= ~shift_q[FW-1];
                  PH1: begin
                    scl_oe_q <= 1'b0;
                    count_q  <= count_q + 7'd1;
                  end
                  PH2: begin
                  end
                  default: begin
                    scl_oe_q <= 1'b1;
                    shift_q  <= {shift_q[FW-2:0], 1'b0};
                    bit_q    <= bit_q + 3'd1;
                    if (bit_q == 3'd7) state_q <= ACKS;
                  end
                endcase
              end

              ACKS: begin
                case (phase_q)
                  PH0: sda_oe_q <= 1'b0;
                  PH1: begin
                    scl_oe_q <= 1'b0;
                    count_q  <= count_q + 7'd1;
                  end
                  PH2: slot_nack_q <= sda_sync_q;
                  default: begin
                    scl_oe_q <= 1'b1;
                    if (slot_nack_q || (byte_q == LAST_BYTE)) begin
                      state_q <= STOP;
                    end else begin
                      byte_q  <= byte_q + 1'b1;
                      state_q <= BYTE;
                    end
                  end
                endcase
              end

              STOP: begin
                case (phase_q)
                  PH0: scl_oe_q <= 1'b1;
                  PH1: sda_oe_q <= 1'b1;
                  PH2: scl_oe_q <= 1'b0;
                  default: begin
                    sda_oe_q <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
                    if (slot_nack_q && (int'(retry_q) < MAX_RETRY)) begin
                      state_q <= BUSFREE;
                    end else begin
                      state_q <= DONE;
                    end
`else
                    state_q <= DONE;
`endif
                  end
                endcase
              end

              BUSFREE: begin
                if (phase_q == PH3) begin
                  shift_q     <= frame_q;
                  count_q     <= '0;
                  bit_q       <= '0;
                  byte_q      <= '0;
                  slot_nack_q <= 1'b0;
`ifdef I2C_NACK_RETRY_EN
                  retry_q     <= retry_q + 8'd1;
`endif
                  state_q     <= START;
                end
              end

              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign scl = scl_oe_q ? 1'b0 : 1'bz;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign busy           = busy_q;
  assign done           = done_q;
  assign ack            = ack_q;
  assign nack_err       = nack_err_q;
  assign send_count_out = count_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_wr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_master_wr : directed bench with an I2C slave/bus monitor model     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_i2c_master_wr;

  logic        meg25 = 1'b0;
  logic        rst   = 1'b1;
  logic        req   = 1'b0;
  logic        sel   = 1'b0;
  logic [23:0] dat   = 24'h0;

  wire scl0, sda0, scl1, sda1;
  pullup (scl0);
  pullup (sda0);
  pullup (scl1);
  pullup (sda1);

  logic       busy0, done0, ack0, nerr0, busy1, done1, ack1, nerr1;
  logic [6:0] cnt0, cnt1;

  always #5 meg25 = ~meg25;

  i2c_master_wr #(.CLK_DIV(4)) u_dut0 (
    .meg25(meg25), .rst(rst), .sendit(req & ~sel), .send_dat(dat),
    .busy(busy0), .done(done0), .ack(ack0), .nack_err(nerr0),
    .send_count_out(cnt0), .scl(scl0), .sda(sda0)
  );

  i2c_master_wr #(.CLK_DIV(4), .REG_BYTES(1), .DAT_BYTES(2)) u_dut1 (
    .meg25(meg25), .rst(rst), .sendit(req & sel), .send_dat(dat),
    .busy(busy1), .done(done1), .ack(ack1), .nack_err(nerr1),
    .send_count_out(cnt1), .scl(scl1), .sda(sda1)
  );

  wire       scl_m  = sel ? scl1  : scl0;
  wire       sda_m  = sel ? sda1  : sda0;
  wire       busy_m = sel ? busy1 : busy0;
  wire       done_m = sel ? done1 : done0;
  wire       ack_m  = sel ? ack1  : ack0;
  wire       nerr_m = sel ? nerr1 : nerr0;
  wire [6:0] cnt_m  = sel ? cnt1  : cnt0;

  // Slave model: shifts in bytes on SCL rises, ACKs after each byte unless
  // nack_mode asks it to reject the address byte.
  int         starts, stops, fcnt, bp;
  logic [7:0] cur;
  logic [7:0] fb [0:7];
  logic       nack_mode = 1'b0;
  logic       s_drive   = 1'b0;

  assign sda0 = (s_drive && !sel) ? 1'b0 : 1'bz;
  assign sda1 = (s_drive &&  sel) ? 1'b0 : 1'bz;

  always @(posedge scl_m) begin
    if (bp < 8) cur = {cur[6:0], sda_m};
    if (bp == 7 && fcnt < 8) begin
      fb[fcnt] = cur;
      fcnt++;
    end
    bp = (bp == 8) ? 0 : bp + 1;
  end

  always @(negedge scl_m) s_drive = (bp == 8) && !(nack_mode && fcnt == 1);

  always @(sda_m) begin
    if (scl_m === 1'b1) begin
      if (sda_m === 1'b0) begin
        starts++;
        bp   = 0;
        fcnt = 0;
      end else if (sda_m === 1'b1) begin
        stops++;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int lat;
  int found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    starts = 0;
    stops  = 0;
    fcnt   = 0;
    bp     = 0;
    for (int i = 0; i < 8; i++) fb[i] = 8'h00;
  endtask

  // Counts clock edges from the accept edge (1) up to the edge showing done.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge meg25);
      #1;
      if (done_m === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    clr_mon();
    rst = 1'b1;
    repeat (3) @(posedge meg25);
    #1;
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_ack",  ack_m,  0);
    chk("rst_nerr", nerr_m, 0);
    chk("rst_cnt",  cnt_m,  0);
    chk("rst_scl",  scl_m,  1);
    chk("rst_sda",  sda_m,  1);
    @(negedge meg25) rst = 1'b0;
    @(posedge meg25);
    #1;

    // Frame A: default parameters, every slot ACKed
    dat = 24'h300882;
    clr_mon();
    req = 1'b1;
    wait_done(lat);
    chk("A_lat",   lat,    602);
    chk("A_cnt",   cnt_m,  36);
    chk("A_ack",   ack_m,  1);
    chk("A_nerr",  nerr_m, 0);
    chk("A_busy",  busy_m, 0);
    chk("A_b0",    fb[0],  8'h78);
    chk("A_b1",    fb[1],  8'h30);
    chk("A_b2",    fb[2],  8'h08);
    chk("A_b3",    fb[3],  8'h82);
    chk("A_nbyte", fcnt,   4);
    chk("A_start", starts, 1);
    chk("A_stop",  stops,  1);
    @(posedge meg25);
    #1;
    chk("A_done_pulse", done_m, 0);

    // sendit held high: no second frame
    repeat (100) @(posedge meg25);
    #1;
    chk("hold_busy",  busy_m, 0);
    chk("hold_start", starts, 1);

    // Frame B: one-cycle drop re-arms; slave NACKs the address byte
    nack_mode = 1'b1;
    req = 1'b0;
    @(posedge meg25);
    #1;
    clr_mon();
    req = 1'b1;
    wait_done(lat);
    chk("B_lat",   lat,    170);
    chk("B_cnt",   cnt_m,  9);
    chk("B_nerr",  nerr_m, 1);
    chk("B_ack",   ack_m,  0);
    chk("B_busy",  busy_m, 0);
    chk("B_b0",    fb[0],  8'h78);
    chk("B_start", starts, 1);
    chk("B_stop",  stops,  1);
    @(posedge meg25);
    #1;
    chk("B_done_pulse", done_m, 0);

    // Reset mid-frame at count 14
    nack_mode = 1'b0;
    req = 1'b0;
    @(posedge meg25);
    #1;
    req = 1'b1;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge meg25);
      #1;
      if (cnt_m == 7'd14) begin
        found = 1;
        break;
      end
    end
    chk("R_reach14", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("R_scl",  scl_m,  1);
    chk("R_sda",  sda_m,  1);
    chk("R_busy", busy_m, 0);
    chk("R_cnt",  cnt_m,  0);
    req = 1'b0;
    @(negedge meg25) rst = 1'b0;
    @(posedge meg25);
    #1;
    clr_mon();
    req = 1'b1;
    wait_done(lat);
    chk("R_lat",   lat,    602);
    chk("R_cnt36", cnt_m,  36);
    chk("R_ack",   ack_m,  1);
    chk("R_b3",    fb[3],  8'h82);
    chk("R_start", starts, 1);
    chk("R_stop",  stops,  1);

    // Second configuration: REG_BYTES=1, DAT_BYTES=2
    req = 1'b0;
    sel = 1'b1;
    dat = 24'hA51234;
    @(posedge meg25);
    #1;
    clr_mon();
    req = 1'b1;
    wait_done(lat);
    chk("C_lat",   lat,    602);
    chk("C_cnt",   cnt_m,  36);
    chk("C_ack",   ack_m,  1);
    chk("C_b0",    fb[0],  8'h78);
    chk("C_b1",    fb[1],  8'hA5);
    chk("C_b2",    fb[2],  8'h12);
    chk("C_b3",    fb[3],  8'h34);
    chk("C_start", starts, 1);
    chk("C_stop",  stops,  1);
    req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
